// File: rtl/pchb_arbiter.sv
// pchb_arbiter
//   Clocked emulation of a precharge-half-buffer two-input arbiter. Two
//   dual-rail input channels (L0, L1) compete for one dual-rail output
//   channel (R). Every channel uses a 4-phase enable handshake.
//
//   Dual-rail encoding: 00 neutral, 01 logic 0, 10 logic 1, 11 illegal.
//
//   Handshake semantics (one rule for all channels): a sender presents a
//   token while the matching enable is high; the receiving side lowers the
//   enable to acknowledge the token. The sender then returns to neutral (00),
//   and the receiving side raises the enable again. R is a token offered to
//   the receiver. The receiver lowers Re to accept it, and R then returns to
//   00.
//
// Ports
//   CLK         in   1  clock, rising edge
//   RESET       in   1  asynchronous active-low reset
//   L0, L1      in   2  dual-rail input channels
//   L0e, L1e    out  1  input channel enables (1 = ready, 0 = token taken)
//   R           out  2  dual-rail output channel
//   Re          in   1  receiver enable (1 = ready, 0 = token accepted)
//   o_dbg_state out  3  current FSM state, for observation only
module pchb_arbiter #(
    parameter bit FAIR = 1'b1
) (
    input  logic       CLK,
    input  logic       RESET,
    input  logic [1:0] L0,
    output logic       L0e,
    input  logic [1:0] L1,
    output logic       L1e,
    output logic [1:0] R,
    input  logic       Re,
    output logic [2:0] o_dbg_state
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_GRANT0 = 3'd1,
        S_GRANT1 = 3'd2,
        S_REL0   = 3'd3,
        S_REL1   = 3'd4
    } state_t;

    state_t     r_state;
    state_t     w_state_nxt;
    logic [1:0] r_tok;      // token captured at grant time
    logic       r_last;     // channel granted most recently
    logic       w_grant;
    logic       w_win;      // 0 = L0 wins, 1 = L1 wins
    logic       w_v0;
    logic       w_v1;

    // Only 01 and 10 are requests. 11 is never captured, so R cannot show 11.
    assign w_v0 = (L0 == 2'b01) || (L0 == 2'b10);
    assign w_v1 = (L1 == 2'b01) || (L1 == 2'b10);

    // State register. The token and round-robin pointer also change only
    // on a grant.
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            r_state <= S_IDLE;
            r_tok   <= 2'b00;
            r_last  <= 1'b1;    // so L0 wins the first tie
        end else begin
            r_state <= w_state_nxt;
            if (w_grant) begin
                r_tok  <= w_win ? L1 : L0;
                r_last <= w_win;
            end
        end
    end

    // Next-state logic
    always_comb begin
        w_state_nxt = r_state;
        w_grant     = 1'b0;
        w_win       = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (Re && (w_v0 || w_v1)) begin
                    w_grant = 1'b1;
                    if (w_v0 && w_v1)
                        w_win = FAIR ? ~r_last : 1'b0;
                    else
                        w_win = w_v1;
                    w_state_nxt = w_win ? S_GRANT1 : S_GRANT0;
                end
            end
            S_GRANT0: if (!Re) w_state_nxt = S_REL0;
            S_GRANT1: if (!Re) w_state_nxt = S_REL1;
            S_REL0:   if (L0 == 2'b00) w_state_nxt = S_IDLE;
            S_REL1:   if (L1 == 2'b00) w_state_nxt = S_IDLE;
            default:  w_state_nxt = S_IDLE;
        endcase
    end

    // Output decode. The outputs depend only on registers, so there is no
    // combinational path from the inputs to the outputs.
    always_comb begin
        R   = 2'b00;
        L0e = 1'b1;
        L1e = 1'b1;
        case (r_state)
            S_GRANT0: begin R = r_tok; L0e = 1'b0; end
            S_GRANT1: begin R = r_tok; L1e = 1'b0; end
            S_REL0:   L0e = 1'b0;
            S_REL1:   L1e = 1'b0;
            default:  ;
        endcase
    end

    assign o_dbg_state = r_state;

endmodule

// File: tb/tb_pchb_arbiter.sv
module tb_pchb_arbiter;

    localparam bit FAIR = 1'b1;

    logic       CLK;
    logic       RESET;
    logic [1:0] L0;
    logic [1:0] L1;
    logic       Re;
    logic       L0e;
    logic       L1e;
    logic [1:0] R;
    logic [2:0] dbg_state;

    int vectors;
    int miscompares;

    // Reference model: which channel owns R (-1 = none), whether the receiver
    // has already taken the token, the token itself, and the last winner.
    int         m_owner;
    bit         m_taken;
    logic [1:0] m_tok;
    int         m_last;

    pchb_arbiter #(.FAIR(FAIR)) dut (
        .CLK        (CLK),
        .RESET      (RESET),
        .L0         (L0),
        .L0e        (L0e),
        .L1         (L1),
        .L1e        (L1e),
        .R          (R),
        .Re         (Re),
        .o_dbg_state(dbg_state)
    );

    // Clock
    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    function automatic bit is_req(input logic [1:0] v);
        return (v == 2'b01) || (v == 2'b10);
    endfunction

    task automatic model_reset();
        m_owner = -1;
        m_taken = 1'b0;
        m_tok   = 2'b00;
        m_last  = 1;
    endtask

    // One clock edge of the arbitration rules, applied to the driven inputs.
    task automatic model_edge();
        int         win;
        logic [1:0] own_in;
        if (m_owner < 0) begin
            if (Re && (is_req(L0) || is_req(L1))) begin
                if (is_req(L0) && is_req(L1))
                    win = FAIR ? 1 - m_last : 0;
                else
                    win = is_req(L0) ? 0 : 1;
                m_owner = win;
                m_tok   = (win == 0) ? L0 : L1;
                m_taken = 1'b0;
                m_last  = win;
            end
        end else if (!m_taken) begin
            if (!Re) m_taken = 1'b1;
        end else begin
            own_in = (m_owner == 0) ? L0 : L1;
            if (own_in == 2'b00) m_owner = -1;
        end
    endtask

    // The expected outputs packed as {R, L0e, L1e}.
    function automatic logic [3:0] model_out();
        logic [1:0] r;
        r = (m_owner >= 0 && !m_taken) ? m_tok : 2'b00;
        return {r, (m_owner != 0), (m_owner != 1)};
    endfunction

    task automatic check(input string tag);
        logic [3:0] obs;
        logic [3:0] exp;
        obs = {R, L0e, L1e};
        exp = model_out();
        vectors++;
        assert (obs === exp)
        else begin
            miscompares++;
            $error("FAIL %s: observed {R,L0e,L1e}=%b expected %b", tag, obs, exp);
        end
    endtask

    // Inputs are driven at the falling edge, the rising edge is applied, and
    // outputs are checked at the next falling edge.
    task automatic drive(input logic [1:0] l0, input logic [1:0] l1, input logic re);
        L0 = l0;
        L1 = l1;
        Re = re;
    endtask

    task automatic step(input string tag);
        @(posedge CLK);
        model_edge();
        @(negedge CLK);
        check(tag);
    endtask

    // Asynchronous reset pulse issued between edges, checked with no clock edge.
    task automatic reset_pulse(input string tag);
        RESET = 1'b0;
        model_reset();
        #1;
        check(tag);
        #1;
        RESET = 1'b1;
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        model_reset();

        // Reset with arbitrary inputs, before any clock edge
        RESET = 1'b0;
        drive(2'b11, 2'b10, 1'b1);
        #1;
        check("reset_async");
        @(negedge CLK);
        check("reset_held");
        RESET = 1'b1;

        // Tie after reset: L0 wins
        drive(2'b10, 2'b10, 1'b1);
        step("tie_first_grant");

        // Return to neutral, then the loser is served
        drive(2'b00, 2'b10, 1'b0);
        step("rtn_r_drop");
        step("rtn_l0e_rise");
        step("rtn_no_grant_re_low");
        drive(2'b00, 2'b10, 1'b1);
        step("loser_served");
        drive(2'b00, 2'b00, 1'b0);
        step("l1_r_drop");
        step("l1_release");

        // Single requester; the token holds while the input changes
        drive(2'b00, 2'b01, 1'b1);
        step("single_grant");
        drive(2'b00, 2'b10, 1'b1);
        step("single_hold_change");
        drive(2'b00, 2'b00, 1'b1);
        step("single_hold_neutral");
        drive(2'b00, 2'b00, 1'b0);
        step("single_r_drop");
        step("single_release");

        // Receiver stall
        drive(2'b01, 2'b00, 1'b1);
        step("stall_grant");
        drive(2'b00, 2'b00, 1'b1);
        for (int i = 0; i < 4; i++) step("stall_hold");
        drive(2'b00, 2'b00, 1'b0);
        step("stall_r_drop");
        step("stall_release");

        // Illegal code is not a request
        drive(2'b11, 2'b00, 1'b1);
        step("illegal_no_grant");
        step("illegal_no_grant2");

        // Reset in GRANT1, then L0 wins the next tie
        drive(2'b00, 2'b01, 1'b1);
        step("pre_reset_grant1");
        reset_pulse("reset_mid_grant");
        drive(2'b10, 2'b10, 1'b1);
        step("tie_after_reset");
        drive(2'b00, 2'b10, 1'b0);
        step("tie2_r_drop");
        step("tie2_release");
        drive(2'b01, 2'b01, 1'b1);
        step("rr_l1_wins");
        drive(2'b01, 2'b00, 1'b0);
        step("rr_r_drop");
        drive(2'b01, 2'b00, 1'b0);
        step("rr_release");

        // Randomized traffic, including illegal codes, early withdrawal and resets
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 59) == 0) begin
                reset_pulse("rand_reset");
            end
            drive(2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)),
                  1'($urandom_range(0, 1)));
            step("random");
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
